// File: rtl/e_mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : e_mdu_pkg
//  Description : Shared definitions for the execute-stage multiply/divide
//                unit. Holds the MDUOp encodings emitted by the decode
//                controller, the default operation latencies, the busy
//                counter width and a start-class decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package e_mdu_pkg;

    // MDUOp encodings shared with the decode-stage controller.
    typedef enum logic [3:0] {
        MDU_none  = 4'd0,
        MDU_mult  = 4'd1,
        MDU_multu = 4'd2,
        MDU_div   = 4'd3,
        MDU_divu  = 4'd4,
        MDU_mfhi  = 4'd5,
        MDU_mflo  = 4'd6,
        MDU_mthi  = 4'd7,
        MDU_mtlo  = 4'd8
    } mdu_op_e;

    // Default busy durations, in cycles, for the multi-cycle operations.
    localparam int unsigned c_MULT_CYCLES_DEFAULT = 5;
    localparam int unsigned c_DIV_CYCLES_DEFAULT  = 10;

    // Busy counter width; latencies must lie in 1 .. 2**c_CNT_W-1.
    localparam int unsigned c_CNT_W = 8;

    // True for the operations that occupy the unit for several cycles.
    function automatic logic mdu_is_start(input logic [3:0] op);
        return (op == MDU_mult) || (op == MDU_multu) ||
               (op == MDU_div)  || (op == MDU_divu);
    endfunction

endpackage
`default_nettype wire

// File: rtl/e_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : e_mdu
//  Description : Execute-stage multiply/divide unit. Owns the architectural
//                HI/LO registers, models a fixed multi-cycle latency for
//                mult/multu/div/divu and serves mfhi/mflo reads.
//
//  Ports:
//    clk     in   1   system clock
//    reset   in   1   synchronous active-high reset
//    valid   in   1   E-stage instruction is live (low for bubble/flush)
//    MDUOp   in   4   operation code (see e_mdu_pkg)
//    A       in  32   forwarded rs value
//    B       in  32   forwarded rt value
//    start   out  1   a multi-cycle operation is accepted this cycle
//    busy    out  1   an operation is in flight (registered)
//    HI      out 32   architectural HI register
//    LO      out 32   architectural LO register
//    MDU_rd  out 32   mfhi/mflo read value, zero for other ops
//
//  Revision    : 1.0 - initial release
// ============================================================================
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = c_MULT_CYCLES_DEFAULT,
    parameter int unsigned DIV_CYCLES  = c_DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDU_rd
);

    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_wr_en;   // shadow result is committed at completion
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_hi_n;
    logic [31:0]        r_lo_n;

    logic               w_is_div;
    logic               w_div_zero;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [63:0]        w_ext_a;
    logic [63:0]        w_ext_b;
    logic [63:0]        w_prod;
    logic [31:0]        w_abs_a;
    logic [31:0]        w_abs_b;
    logic [31:0]        w_uq;
    logic [31:0]        w_ur;
    logic [31:0]        w_hi_res;
    logic [31:0]        w_lo_res;

    assign start  = valid && mdu_is_start(MDUOp) && !r_busy;
    assign busy   = r_busy;
    assign HI     = r_hi;
    assign LO     = r_lo;

    assign w_is_div   = (MDUOp == MDU_div) || (MDUOp == MDU_divu);
    assign w_div_zero = (B == 32'd0);

    // Result datapath. Signed multiply uses sign-extended operands so the
    // low 64 bits of a single unsigned multiplier give the right product.
    // Signed divide runs on magnitudes and re-applies the signs, which makes
    // 0x80000000 / -1 fall out naturally as 0x80000000 with remainder 0.
    always_comb begin
        w_ext_a  = (MDUOp == MDU_mult) ? {{32{A[31]}}, A} : {32'd0, A};
        w_ext_b  = (MDUOp == MDU_mult) ? {{32{B[31]}}, B} : {32'd0, B};
        w_prod   = w_ext_a * w_ext_b;

        w_sign_a = (MDUOp == MDU_div) && A[31];
        w_sign_b = (MDUOp == MDU_div) && B[31];
        w_abs_a  = w_sign_a ? (32'd0 - A) : A;
        // A zero divisor is replaced by 1 only to keep the divider defined;
        // the result is discarded at completion.
        w_abs_b  = w_div_zero ? 32'd1 : (w_sign_b ? (32'd0 - B) : B);
        w_uq     = w_abs_a / w_abs_b;
        w_ur     = w_abs_a % w_abs_b;

        if (w_is_div) begin
            w_lo_res = (w_sign_a ^ w_sign_b) ? (32'd0 - w_uq) : w_uq;
            w_hi_res = w_sign_a ? (32'd0 - w_ur) : w_ur;
        end else begin
            w_lo_res = w_prod[31:0];
            w_hi_res = w_prod[63:32];
        end
    end

    always_comb begin
        MDU_rd = 32'd0;
        if (MDUOp == MDU_mfhi) begin
            MDU_rd = r_hi;
        end else if (MDUOp == MDU_mflo) begin
            MDU_rd = r_lo;
        end
    end

    // Busy/countdown and HI/LO update. While busy every new request is
    // dropped; mthi/mtlo only act when the unit is idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_wr_en <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_hi_n  <= 32'd0;
            r_lo_n  <= 32'd0;
        end else if (r_busy) begin
            if (r_cnt == c_CNT_W'(1)) begin
                r_cnt  <= '0;
                r_busy <= 1'b0;
                if (r_wr_en) begin
                    r_hi <= r_hi_n;
                    r_lo <= r_lo_n;
                end
            end else begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
        end else if (start) begin
            r_hi_n  <= w_hi_res;
            r_lo_n  <= w_lo_res;
            r_wr_en <= !(w_is_div && w_div_zero);
            r_cnt   <= w_is_div ? c_DIV_LOAD : c_MULT_LOAD;
            r_busy  <= 1'b1;
        end else if (valid && (MDUOp == MDU_mthi)) begin
            r_hi <= A;
        end else if (valid && (MDUOp == MDU_mtlo)) begin
            r_lo <= A;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_e_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_e_mdu
//  Description : Self-checking bench for e_mdu. A driver issues directed and
//                random operations against a cycle-level reference model and
//                pushes each expected multi-cycle result into a scoreboard
//                queue; a monitor pops and checks on every busy completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_e_mdu;
    import e_mdu_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDU_rd;

    e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk    (clk),
        .reset  (reset),
        .valid  (valid),
        .MDUOp  (MDUOp),
        .A      (A),
        .B      (B),
        .start  (start),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO),
        .MDU_rd (MDU_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: architectural HI/LO, a pending result and the
    // first cycle in which the unit is free again.
    logic [31:0] m_hi = 0, m_lo = 0, pend_hi = 0, pend_lo = 0;
    bit          pend = 0, pend_wr = 0;
    int          cyc = 0, free_at = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Architectural arithmetic straight from the instruction definitions.
    task automatic ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] hi, output logic [31:0] lo, output bit wr);
        longint      sa, sb, q, r;
        logic [63:0] p;
        wr = 1;
        hi = 0;
        lo = 0;
        case (op)
            MDU_mult: begin
                sa = $signed(a);
                sb = $signed(b);
                p  = sa * sb;
                {hi, lo} = p;
            end
            MDU_multu: begin
                p = {32'd0, a} * {32'd0, b};
                {hi, lo} = p;
            end
            MDU_div: begin
                if (b == 0) wr = 0;
                else begin
                    sa = $signed(a);
                    sb = $signed(b);
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = q[31:0];
                    hi = r[31:0];
                end
            end
            default: begin
                if (b == 0) wr = 0;
                else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endtask

    // One clock cycle of stimulus with model update and per-cycle checks.
    task automatic step(input bit v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] rhi, rlo, exp_rd;
        bit          wr, bsy, exp_st;
        exp_t        e;
        if (pend && cyc >= free_at) begin
            if (pend_wr) begin
                m_hi = pend_hi;
                m_lo = pend_lo;
            end
            pend = 0;
        end
        bsy    = (cyc < free_at);
        valid  = v;
        MDUOp  = op;
        A      = a;
        B      = b;
        exp_rd = (op == MDU_mfhi) ? m_hi : (op == MDU_mflo) ? m_lo : 32'd0;
        exp_st = v && (op inside {MDU_mult, MDU_multu, MDU_div, MDU_divu}) && !bsy;
        if (exp_st) begin
            ref_result(op, a, b, rhi, rlo, wr);
            pend    = 1;
            pend_wr = wr;
            pend_hi = rhi;
            pend_lo = rlo;
            e.lat   = (op inside {MDU_div, MDU_divu}) ? DIV_N : MULT_N;
            free_at = cyc + 1 + e.lat;
            e.hi    = wr ? rhi : m_hi;
            e.lo    = wr ? rlo : m_lo;
            sb_q.push_back(e);
        end else if (v && !bsy && op == MDU_mthi) begin
            m_hi = a;
        end else if (v && !bsy && op == MDU_mtlo) begin
            m_lo = a;
        end
        @(negedge clk);
        cmp("start", {31'd0, start}, {31'd0, exp_st});
        cmp("mdu_rd", MDU_rd, exp_rd);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, MDU_none, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1;
        valid = 0;
        MDUOp = MDU_none;
        sb_q.delete();
        m_hi = 0; m_lo = 0; pend = 0; free_at = 0;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 0;
        cyc++;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Monitor: measures each busy pulse and checks it against the scoreboard.
    initial begin : monitor
        int cnt;
        bit prev;
        exp_t e;
        cnt  = 0;
        prev = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cnt  = 0;
                prev = 0;
            end else begin
                if (busy) cnt++;
                else if (prev) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL completion: got unexpected result hi=%h lo=%h expected none", HI, LO);
                    end else begin
                        e = sb_q.pop_front();
                        cmp("busy_len", 32'(cnt), 32'(e.lat));
                        cmp("res_hi", HI, e.hi);
                        cmp("res_lo", LO, e.lo);
                    end
                    cnt = 0;
                end
                prev = busy;
            end
        end
    end

    initial begin : driver
        bit          v;
        logic [3:0]  op;
        reset = 1; valid = 0; MDUOp = MDU_none; A = 0; B = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;

        // Reset state.
        cmp("rst_hi", HI, 32'd0);
        cmp("rst_lo", LO, 32'd0);
        cmp("rst_busy", {31'd0, busy}, 32'd0);
        step(1, MDU_mfhi, 32'd0, 32'd0);

        // mult / multu of 0xFFFFFFFF * 2.
        step(1, MDU_mult, 32'hFFFF_FFFF, 32'd2);
        idle(MULT_N);
        cmp("mult_busy", {31'd0, busy}, 32'd0);
        cmp("mult_hi", HI, 32'hFFFF_FFFF);
        cmp("mult_lo", LO, 32'hFFFF_FFFE);
        step(1, MDU_multu, 32'hFFFF_FFFF, 32'd2);
        idle(MULT_N);
        cmp("multu_hi", HI, 32'h0000_0001);
        cmp("multu_lo", LO, 32'hFFFF_FFFE);

        // Signed divides.
        step(1, MDU_div, 32'hFFFF_FFF9, 32'd2);
        idle(DIV_N);
        cmp("div_lo", LO, 32'hFFFF_FFFD);
        cmp("div_hi", HI, 32'hFFFF_FFFF);
        step(1, MDU_div, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DIV_N);
        cmp("divovf_lo", LO, 32'h8000_0000);
        cmp("divovf_hi", HI, 32'd0);

        // divu by zero keeps HI/LO.
        step(1, MDU_mthi, 32'h11, 32'd0);
        step(1, MDU_mtlo, 32'h22, 32'd0);
        step(1, MDU_divu, 32'h1234, 32'd0);
        idle(DIV_N);
        cmp("div0_hi", HI, 32'h11);
        cmp("div0_lo", LO, 32'h22);

        // Requests while busy are ignored.
        step(1, MDU_mult, 32'd3, 32'd5);
        step(1, MDU_mult, 32'd7, 32'd7);
        step(1, MDU_mthi, 32'h55, 32'd0);
        idle(MULT_N - 2);
        cmp("ign_hi", HI, 32'd0);
        cmp("ign_lo", LO, 32'd15);

        // Reset in busy cycle 3 of a divide.
        step(1, MDU_div, 32'd100, 32'd7);
        idle(2);
        do_reset();
        cmp("abort_busy", {31'd0, busy}, 32'd0);
        cmp("abort_hi", HI, 32'd0);
        cmp("abort_lo", LO, 32'd0);
        step(1, MDU_mtlo, 32'h9, 32'd0);
        cmp("abort_mtlo", LO, 32'h9);
        idle(DIV_N + 2);
        cmp("abort_hi2", HI, 32'd0);
        cmp("abort_lo2", LO, 32'h9);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2) do_reset();
            else begin
                v  = ($urandom_range(0, 9) != 0);
                op = 4'($urandom_range(0, 8));
                step(v, op, pick(), pick());
            end
        end

        // Drain outstanding results within a bounded window.
        for (int i = 0; i < DIV_N + 5 && sb_q.size() != 0; i++) idle(1);
        idle(1);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending results expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit. It consumes the MDUOp that the decode-stage controller produces for mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
- It models fixed multi-cycle latency and owns the architectural HI/LO registers.
- It reports start/busy to the hazard unit, which stalls the D stage on any HI/LO-related instruction while the unit is occupied.
- It supplies the mfhi/mflo read value to the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu.
- DIV_CYCLES, 10, busy duration in cycles for div/divu.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- valid  input  1  E-stage instruction is live; low for a bubble or flush.
- MDUOp  input  4  operation code from the shared define set.
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- start  output  1  combinational: valid & MDUOp is mult/multu/div/divu & !busy.
- busy  output  1  registered: an operation is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- MDU_rd  output  32  combinational: HI when MDUOp=mfhi, LO when MDUOp=mflo, else 0.

Behaviour:
- Reset (takes effect at the clock edge while reset=1, including mid-operation):
  - HI=0, LO=0, busy=0, counter=0.
  - Shadow results are cleared and any in-flight result is discarded.
- Start:
  - When start=1 at an edge, the result is computed from A/B sampled that cycle into shadow registers hi_n/lo_n.
  - counter loads MULT_CYCLES or DIV_CYCLES, and busy becomes 1 on the next cycle.
  - HI/LO are not yet changed.
- Countdown:
  - While busy, counter decrements each cycle.
  - On the edge where counter==1: HI<=hi_n, LO<=lo_n, busy<=0.
  - busy is therefore high for exactly N cycles after the start cycle. New HI/LO are visible in the first cycle busy=0.
- Arithmetic:
  - mult: signed 32x32→64; multu: unsigned 32x32→64. {HI,LO} = product.
  - div: signed; LO = quotient truncated toward zero, HI = remainder carrying the dividend's sign.
  - divu: unsigned quotient/remainder.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
  - Divide by zero (B=0) still occupies DIV_CYCLES busy cycles; HI/LO are left unchanged at completion.
- mthi/mtlo:
  - When valid & !busy, HI<=A (mthi) or LO<=A (mtlo) at the edge, with zero latency.
  - When busy, they are ignored; the hazard unit guarantees they are never issued then.
- Ignored inputs:
  - start-class ops while busy are ignored, so start stays 0 and state is unchanged.
  - valid=0 masks every write; MDUOp none writes nothing.
- Reads: mfhi/mflo read is combinational from the current HI/LO and is not gated by busy; the hazard unit stalls reads during busy.

Decomposition:
- Shared define file gains the MDUOp encodings:
  - MDU_none=0, MDU_mult=1, MDU_multu=2, MDU_div=3, MDU_divu=4, MDU_mfhi=5, MDU_mflo=6, MDU_mthi=7, MDU_mtlo=8.
- The default latency constants live in the same define file.
- No sub-module; the counter/busy state and the HI/LO registers sit in e_mdu.
- The decode controller is extended to emit MDUOp plus D-stage is_md (any of the 8 ops) for the hazard unit. Stall condition: is_md_D & (E.start | E.busy).

Test Plan:
- Reset then idle → HI=0, LO=0, busy=0, MDU_rd=0 with MDUOp=mfhi.
- mult with A=0xFFFFFFFF, B=2 → start=1 in cycle 0, busy=1 in cycles 1–5; cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands with multu → HI=0x00000001, LO=0xFFFFFFFE.
- Signed divide cases:
  - div A=-7 (0xFFFFFFF9), B=2 → busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- divu with B=0 after mthi 0x11 and mtlo 0x22 → busy for 10 cycles; HI=0x11 and LO=0x22 are preserved.
- Second mult issued while busy, and mthi 0x55 issued while busy → start=0, mthi ignored, and the original result lands on schedule.
- reset asserted at busy cycle 3 of a div → next cycle busy=0, HI=LO=0. The aborted result never appears, and a fresh mtlo 0x9 writes LO=0x9 one edge later.
